seg7_fade_driver: RTL

- Output stage between the segment pattern decoders (digit and animation decoders) and the 7-segment pins.
- Takes the 7-bit segment pattern each decoder produces and drives the display with PWM brightness control.
- When the pattern changes, it optionally cross-fades: the old pattern dims to dark, then the new pattern ramps up to the brightness setting.
- Keeps the counter and animation logic unchanged while giving smooth frame transitions.

---
 rtl/seg7_fade_driver.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/seg7_fade_driver.sv
// PWM-dimmed 7-segment output stage. On a pattern change it can cross-fade:
// the old pattern dims to dark, then the new pattern ramps up to the target level.
module seg7_fade_driver #(
    parameter int PWM_BITS     = 4,
    parameter int STEP_PERIODS = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          seg_in,
    input  logic                seg_valid,
    input  logic                fade_en,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [6:0]          seg_out,
    output logic                busy
);

    localparam int STEP_BITS = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [PWM_BITS-1:0]  PWM_MAX   = '1;
    localparam logic [STEP_BITS-1:0] STEP_LAST = STEP_BITS'(STEP_PERIODS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FADE_OUT,
        FADE_IN
    } state_t;

    state_t               state, state_next;
    logic [6:0]           cur_pat, cur_pat_next;
    logic [6:0]           new_pat, new_pat_next;
    logic                 pending, pending_next;
    logic [PWM_BITS-1:0]  level, level_next;
    logic [PWM_BITS-1:0]  pwm_cnt, pwm_cnt_next;
    logic [STEP_BITS-1:0] step_cnt, step_cnt_next;
    logic                 pwm_wrap;
    logic                 step_edge;
    logic [6:0]           pat_eff;
    logic                 pend_eff;
    logic                 duty_on;
    logic [6:0]           lit;

    assign pwm_wrap  = (pwm_cnt == PWM_MAX);
    assign step_edge = pwm_wrap && (step_cnt == STEP_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cur_pat  <= '0;
            new_pat  <= '0;
            pending  <= 1'b0;
            level    <= '0;
            pwm_cnt  <= '0;
            step_cnt <= '0;
            seg_out  <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            cur_pat  <= cur_pat_next;
            new_pat  <= new_pat_next;
            pending  <= pending_next;
            level    <= level_next;
            pwm_cnt  <= pwm_cnt_next;
            step_cnt <= step_cnt_next;
            seg_out  <= lit;
            busy     <= (state != IDLE);
        end
    end

    // A seg_valid arriving on a step boundary is folded in before the boundary decision.
    always_comb begin
        state_next    = state;
        cur_pat_next  = cur_pat;
        new_pat_next  = new_pat;
        pending_next  = pending;
        level_next    = level;
        pwm_cnt_next  = pwm_cnt + 1'b1;
        step_cnt_next = step_cnt;
        pat_eff       = seg_valid ? seg_in : new_pat;
        pend_eff      = pending | seg_valid;

        if (step_edge) begin
            step_cnt_next = '0;
        end else if (pwm_wrap) begin
            step_cnt_next = step_cnt + 1'b1;
        end

        unique case (state)
            IDLE: begin
                level_next = brightness;
                if (seg_valid && (seg_in != cur_pat)) begin
                    if (fade_en) begin
                        new_pat_next  = seg_in;
                        pwm_cnt_next  = '0;
                        step_cnt_next = '0;
                        level_next    = level;
                        state_next    = FADE_OUT;
                    end else begin
                        cur_pat_next = seg_in;
                    end
                end
            end
            FADE_OUT: begin
                new_pat_next = pat_eff;
                if (step_edge) begin
                    if (level == '0) begin
                        cur_pat_next = pat_eff;
                        state_next   = FADE_IN;
                    end else begin
                        level_next = level - 1'b1;
                    end
                end
            end
            FADE_IN: begin
                new_pat_next = pat_eff;
                pending_next = pend_eff;
                if (step_edge) begin
                    if (level >= brightness) begin
                        level_next   = brightness;
                        pending_next = 1'b0;
                        if (pend_eff && (pat_eff != cur_pat)) begin
                            pwm_cnt_next  = '0;
                            step_cnt_next = '0;
                            state_next    = FADE_OUT;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        level_next = level + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        duty_on = (level == PWM_MAX) || (pwm_cnt < level);
        lit     = cur_pat & {7{duty_on}};
    end

endmodule
